// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the pipelined FFT datapath stages.
//   - MODE_BF1 / MODE_BF2 : butterfly flavour selectors for sdf_r2_stage.
//   - phase_e             : fill / butterfly half of an SDF frame.
//   - clog2()             : ceiling log2, usable in constant expressions.
//   - round_shift()       : optional divide-by-2 with round-half-up on a
//                           value the caller has already sign-extended to
//                           CALC_W bits.
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int MODE_BF1 = 0;   // plain radix-2 butterfly
    localparam int MODE_BF2 = 1;   // radix-2^2 BF-II with trivial -j rotation
    localparam int CALC_W   = 32;  // working width for the scaling helper

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // scale=1 returns (value + 1) >>> 1 (arithmetic), scale=0 passes through.
    function automatic logic signed [CALC_W-1:0] round_shift(
        input logic signed [CALC_W-1:0] value,
        input logic                     scale
    );
        logic signed [CALC_W-1:0] biased;
        biased = value + 32'sd1;
        return scale ? (biased >>> 1) : value;
    endfunction

endpackage

// File: rtl/sdf_delay_line.sv
// -----------------------------------------------------------------------------
// sdf_delay_line
//   Fixed-length circular delay buffer for the SDF feedback path. On every
//   enabled cycle the entry at the pointer is read (dout) and overwritten by
//   din, so dout is always the value written DEPTH enabled cycles earlier.
//   Reads as zero everywhere after reset.
//
// Ports
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   en    in   advance: write din, step the pointer
//   din   in   [W-1:0] value pushed into the line
//   dout  out  [W-1:0] current head (oldest entry), combinational
// -----------------------------------------------------------------------------
module sdf_delay_line
    import fft_pkg::*;
#(
    parameter int W     = 22,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int            PW   = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr;

    // NOTE: every clocked block uses non-blocking (<=) so all registers update
    // together from pre-edge values; blocking here would create order races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            logic [W-1:0] stage;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage <= '0;
                end else if (en) begin
                    stage <= din;
                end
            end

            assign dout = stage;
        end else if (DEPTH <= 4) begin : g_regs
            logic [W-1:0] regs [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        regs[i] <= '0;
                    end
                end else if (en) begin
                    regs[ptr] <= din;
                end
            end

            assign dout = regs[ptr];
        end else begin : g_ram
            logic [W-1:0] mem [DEPTH];
            logic         wrapped;

            // NOTE: the storage array has no reset so it can map onto RAM;
            // until the pointer has gone round once, the entry under the
            // pointer has never been written, so 'wrapped' forces the head to
            // zero and the line behaves exactly like a cleared buffer.
            always_ff @(posedge clk) begin
                if (en) begin
                    mem[ptr] <= din;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wrapped <= 1'b0;
                end else if (en && (ptr == LAST)) begin
                    wrapped <= 1'b1;
                end
            end

            assign dout = wrapped ? mem[ptr] : '0;
        end
    endgenerate

endmodule

// File: rtl/sdf_r2_stage.sv
// -----------------------------------------------------------------------------
// sdf_r2_stage
//   Radix-2 single-path delay-feedback butterfly stage. Each frame is 2*DEPTH
//   samples: the first half fills the feedback line, the second half forms
//   d + x (emitted) and d - x (fed back, emitted during the next fill half).
//   MODE_BF2 multiplies the second half of every other frame by -j before the
//   butterfly. SCALE=1 halves the emitted result with rounding.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   sample qualifier; low freezes all state
//   in_sof     in   first sample of an input frame (only with in_valid)
//   in_re      in   [IN_W-1:0]  signed real input
//   in_im      in   [IN_W-1:0]  signed imaginary input
//   out_valid  out  output qualifier
//   out_sof    out  first sample of an output frame
//   out_re     out  [OUT_W-1:0] signed real output
//   out_im     out  [OUT_W-1:0] signed imaginary output
//   err_sof    out  one-cycle pulse after an in_sof seen at a non-zero phase
// -----------------------------------------------------------------------------
module sdf_r2_stage
    import fft_pkg::*;
#(
    parameter  int IN_W  = 10,
    parameter  int DEPTH = 32,
    parameter  int MODE  = MODE_BF1,
    parameter  int SCALE = 0,
    localparam int OUT_W = IN_W + 1 - SCALE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    output logic                    out_valid,
    output logic                    out_sof,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im,
    output logic                    err_sof
);

    localparam int            AW       = IN_W + 1;
    localparam int            CW       = clog2(2 * DEPTH);
    localparam logic [CW-1:0] CNT_HALF = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(2 * DEPTH - 1);

    logic [CW-1:0] cnt;
    logic          rot;
    logic          primed;

    logic          resync;
    logic [CW-1:0] cnt_eff;
    logic          rot_eff;
    logic          primed_eff;
    logic          rot_nxt;
    phase_e        phase;

    logic signed [AW-1:0]    x_re, x_im;
    logic signed [AW-1:0]    d_re, d_im;
    logic signed [AW-1:0]    res_re, res_im;
    logic signed [AW-1:0]    fb_re, fb_im;
    logic        [2*AW-1:0]  head;
    logic signed [OUT_W-1:0] out_re_nxt, out_im_nxt;

    // Real part in the upper half, imaginary in the lower half.
    sdf_delay_line #(
        .W     (2 * AW),
        .DEPTH (DEPTH)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (in_valid),
        .din  ({fb_re, fb_im}),
        .dout (head)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        resync     = 1'b0;
        cnt_eff    = cnt;
        rot_eff    = 1'b0;
        primed_eff = primed;
        rot_nxt    = 1'b0;
        phase      = PH_FILL;
        x_re       = AW'(in_re);
        x_im       = AW'(in_im);
        d_re       = $signed(head[2*AW-1:AW]);
        d_im       = $signed(head[AW-1:0]);
        res_re     = '0;
        res_im     = '0;
        fb_re      = '0;
        fb_im      = '0;

        // A frame start at a non-zero phase realigns: this sample becomes
        // phase 0 and the stage must re-prime before emitting again.
        resync = in_valid && in_sof && (cnt != '0);
        if (resync) begin
            cnt_eff    = '0;
            primed_eff = 1'b0;
        end
        rot_eff = (MODE == MODE_BF2) && rot && !resync;
        rot_nxt = rot_eff ^ ((MODE == MODE_BF2) && (cnt_eff == CNT_LAST));

        if (cnt_eff >= CNT_HALF) begin
            phase = PH_BFLY;
        end

        // x * (-j) = (im, -re); done at AW bits so negating -2^(IN_W-1) fits.
        if ((phase == PH_BFLY) && rot_eff) begin
            x_re = AW'(in_im);
            x_im = -AW'(in_re);
        end

        if (phase == PH_BFLY) begin
            res_re = d_re + x_re;
            res_im = d_im + x_im;
            fb_re  = d_re - x_re;
            fb_im  = d_im - x_im;
        end else begin
            res_re = d_re;
            res_im = d_im;
            fb_re  = x_re;
            fb_im  = x_im;
        end
    end

    // Scaling touches only the emitted value; the feedback stays full width.
    assign out_re_nxt = OUT_W'(round_shift(CALC_W'(res_re), SCALE != 0));
    assign out_im_nxt = OUT_W'(round_shift(CALC_W'(res_im), SCALE != 0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            rot       <= 1'b0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            err_sof   <= 1'b0;
        end else begin
            err_sof   <= resync;
            // The phase-DEPTH sample is the first butterfly output and primes.
            out_valid <= in_valid && (primed_eff || (cnt_eff == CNT_HALF));
            out_sof   <= in_valid && (cnt_eff == CNT_HALF);
            if (in_valid) begin
                cnt    <= (cnt_eff == CNT_LAST) ? '0 : cnt_eff + CW'(1);
                rot    <= rot_nxt;
                primed <= primed_eff || (cnt_eff == CNT_HALF);
                out_re <= out_re_nxt;
                out_im <= out_im_nxt;
            end
        end
    end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// -----------------------------------------------------------------------------
// tb_sdf_r2_stage
//   Directed bench for sdf_r2_stage with DEPTH=4, IN_W=10. Three instances
//   share one stimulus stream: BF-I full growth (a), BF-I scaled (s) and
//   BF-II full growth (b). Inputs change on the falling edge; outputs are
//   checked on the following falling edge.
// -----------------------------------------------------------------------------
module tb_sdf_r2_stage;

    localparam int DC = 32'h7fff_ffff;  // "don't check" marker for data fields

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0;
    logic              in_sof   = 1'b0;
    logic signed [9:0] in_re    = '0;
    logic signed [9:0] in_im    = '0;

    logic               a_valid, a_sof, a_err;
    logic signed [10:0] a_re, a_im;
    logic               s_valid, s_sof, s_err;
    logic signed [9:0]  s_re, s_im;
    logic               b_valid, b_sof, b_err;
    logic signed [10:0] b_re, b_im;

    int checks   = 0;
    int failures = 0;

    // BF-II two-frame vectors and hand-computed outputs (16 outputs).
    int f_re[16] = '{1, 2, 0, 4, 1, -2, 2, 0,  3, -1, 2, 1,  3, 2, -4, 1};
    int f_im[16] = '{0, 1, -1, 2, 1, 3, 2, 5,  1, 2, 0, -4,  5, -1, 0, 1};
    int e_re[16] = '{2, 0, 2, 4,  0, 4, -2, 4,  8, -2, 2, 2,  -2, 0, 2, 0};
    int e_im[16] = '{1, 4, 1, 7,  -1, -2, -3, -3,  -2, 0, 4, -5,  4, 4, -4, -3};
    int e_f1[4]  = '{6, 8, 10, 12};

    sdf_r2_stage #(.IN_W(10), .DEPTH(4), .MODE(0), .SCALE(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .out_valid(a_valid), .out_sof(a_sof),
        .out_re(a_re), .out_im(a_im), .err_sof(a_err)
    );

    sdf_r2_stage #(.IN_W(10), .DEPTH(4), .MODE(0), .SCALE(1)) u_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .out_valid(s_valid), .out_sof(s_sof),
        .out_re(s_re), .out_im(s_im), .err_sof(s_err)
    );

    sdf_r2_stage #(.IN_W(10), .DEPTH(4), .MODE(1), .SCALE(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .out_valid(b_valid), .out_sof(b_sof),
        .out_re(b_re), .out_im(b_im), .err_sof(b_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // sel: 0 = u_a, 1 = u_s, 2 = u_b
    task automatic chk_out(input int sel, input string tag, input int v,
                           input int s, input int re, input int im, input int err);
        int ov, os, ore, oim, oerr;
        case (sel)
            0: begin ov = int'(a_valid); os = int'(a_sof); ore = int'(a_re);
                     oim = int'(a_im); oerr = int'(a_err); end
            1: begin ov = int'(s_valid); os = int'(s_sof); ore = int'(s_re);
                     oim = int'(s_im); oerr = int'(s_err); end
            default: begin ov = int'(b_valid); os = int'(b_sof); ore = int'(b_re);
                     oim = int'(b_im); oerr = int'(b_err); end
        endcase
        check({tag, ".valid"}, ov, v);
        check({tag, ".sof"}, os, s);
        check({tag, ".err"}, oerr, err);
        if (re != DC) check({tag, ".re"}, ore, re);
        if (im != DC) check({tag, ".im"}, oim, im);
    endtask

    task automatic push(input logic v, input logic s, input int re, input int im);
        in_valid = v;
        in_sof   = s;
        in_re    = 10'(re);
        in_im    = 10'(im);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_re    = '0;
        in_im    = '0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
    endtask

    // Real ramp 1..8 then four zeros: 6,8,10,12 then -4 x4.
    task automatic run_frame1(input string tag);
        for (int i = 1; i <= 4; i++) begin
            push(1'b1, i == 1, i, 0);
            chk_out(0, {tag, ".fill"}, 0, 0, DC, DC, 0);
        end
        for (int i = 5; i <= 8; i++) begin
            push(1'b1, 1'b0, i, 0);
            chk_out(0, {tag, ".bfly"}, 1, (i == 5) ? 1 : 0, e_f1[i-5], 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 1'b0, 0, 0);
            chk_out(0, {tag, ".flush"}, 1, 0, -4, 0, 0);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_out(0, "rst_a", 0, 0, 0, 0, 0);
        chk_out(1, "rst_s", 0, 0, 0, 0, 0);
        chk_out(2, "rst_b", 0, 0, 0, 0, 0);

        // Basic BF-I frame
        run_frame1("frame1");

        // Stall between samples 6 and 7; in_sof without in_valid is ignored
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            push(1'b1, i == 1, i, 0);
            chk_out(0, "stall.fill", 0, 0, DC, DC, 0);
        end
        push(1'b1, 1'b0, 5, 0);
        chk_out(0, "stall.s5", 1, 1, 6, 0, 0);
        push(1'b1, 1'b0, 6, 0);
        chk_out(0, "stall.s6", 1, 0, 8, 0, 0);
        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b1, 99, 99);
            chk_out(0, "stall.hold", 0, 0, 8, 0, 0);
        end
        push(1'b1, 1'b0, 7, 0);
        chk_out(0, "stall.s7", 1, 0, 10, 0, 0);
        push(1'b1, 1'b0, 8, 0);
        chk_out(0, "stall.s8", 1, 0, 12, 0, 0);
        push(1'b1, 1'b0, 0, 0);
        chk_out(0, "stall.flush", 1, 0, -4, 0, 0);

        // SCALE=1 extremes and rounding
        do_reset();
        push(1'b1, 1'b1, 511, 0);
        push(1'b1, 1'b0, -512, 0);
        push(1'b1, 1'b0, 3, 0);
        push(1'b1, 1'b0, 0, 0);
        chk_out(1, "scale.fill", 0, 0, DC, DC, 0);
        push(1'b1, 1'b0, 511, 0);
        chk_out(1, "scale.max", 1, 1, 511, 0, 0);
        push(1'b1, 1'b0, -512, 0);
        chk_out(1, "scale.min", 1, 0, -512, 0, 0);
        push(1'b1, 1'b0, 0, 0);
        chk_out(1, "scale.rnd", 1, 0, 2, 0, 0);
        push(1'b1, 1'b0, 0, 0);
        chk_out(1, "scale.zero", 1, 0, 0, 0, 0);
        push(1'b1, 1'b0, 0, 0);
        chk_out(1, "scale.d0", 1, 0, 0, 0, 0);
        push(1'b1, 1'b0, 0, 0);
        chk_out(1, "scale.d1", 1, 0, 0, 0, 0);
        push(1'b1, 1'b0, 0, 0);
        chk_out(1, "scale.d2", 1, 0, 2, 0, 0);

        // BF-II: two back-to-back frames, second half of frame 2 rotated
        do_reset();
        for (int i = 0; i < 20; i++) begin
            push(1'b1, (i == 0) || (i == 8), (i < 16) ? f_re[i] : 0,
                 (i < 16) ? f_im[i] : 0);
            if (i < 4) chk_out(2, "bf2.pre", 0, 0, DC, DC, 0);
            else chk_out(2, $sformatf("bf2.o%0d", i - 4), 1,
                         ((i == 4) || (i == 12)) ? 1 : 0, e_re[i-4], e_im[i-4], 0);
        end

        // Misaligned in_sof at phase 5 after priming
        do_reset();
        for (int i = 1; i <= 4; i++) push(1'b1, i == 1, i, 0);
        push(1'b1, 1'b0, 5, 0);
        chk_out(0, "mis.primed", 1, 1, 6, 0, 0);
        push(1'b1, 1'b1, 6, 0);
        chk_out(0, "mis.resync", 0, 0, DC, DC, 1);
        for (int i = 7; i <= 9; i++) begin
            push(1'b1, 1'b0, i, 0);
            chk_out(0, "mis.refill", 0, 0, DC, DC, 0);
        end
        push(1'b1, 1'b0, 10, 0);
        chk_out(0, "mis.sof", 1, 1, 16, 0, 0);
        push(1'b1, 1'b0, 11, 0);
        chk_out(0, "mis.next", 1, 0, 18, 0, 0);

        // Asynchronous reset mid-frame, then a clean repeat of frame 1
        do_reset();
        for (int i = 1; i <= 6; i++) push(1'b1, i == 1, i, 0);
        chk_out(0, "midrst.pre", 1, 0, 8, 0, 0);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b1;
        #1;
        chk_out(0, "midrst.a", 0, 0, 0, 0, 0);
        chk_out(2, "midrst.b", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_frame1("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
